// File: rtl/parking_lot_monitor_if.sv
// ---------------------------------------------------------------------------
// parking_lot_monitor_if
// Bundles the sensor inputs and occupancy outputs of parking_lot_monitor.
//   a, b     : per-lane outer/inner photo-sensor levels (1 = beam blocked)
//   clr_err  : synchronous clear of the sticky error bits
//   enter    : per-lane 1-cycle pulse on a completed entry
//   exit     : per-lane 1-cycle pulse on a completed exit
//   count    : current occupancy
//   full     : count == CAPACITY
//   empty    : count == 0
//   err      : sticky, [0] entry refused at capacity, [1] exit at zero
// Modports: master = sensor/controller side, slave = monitor side.
// ---------------------------------------------------------------------------
interface parking_lot_monitor_if #(
  parameter int N_LANES = 2,
  parameter int CNT_W   = 8
);
  logic [N_LANES-1:0] a;
  logic [N_LANES-1:0] b;
  logic               clr_err;
  logic [N_LANES-1:0] enter;
  logic [N_LANES-1:0] exit;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [1:0]         err;

  modport master (
    output a, b, clr_err,
    input  enter, exit, count, full, empty, err
  );

  modport slave (
    input  a, b, clr_err,
    output enter, exit, count, full, empty, err
  );
endinterface

// File: rtl/parking_lot_monitor.sv
// ---------------------------------------------------------------------------
// parking_lot_monitor
// Multi-lane parking gate monitor. Each lane has an outer (a) and inner (b)
// photo-sensor; both are synchronized and debounced, then a per-lane FSM
// recognises complete entry (a, ab, b, none) and exit (b, ab, a, none)
// sequences. A shared saturating occupancy counter tracks the lot.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : parking_lot_monitor_if.slave (a, b, clr_err in;
//            enter, exit, count, full, empty, err out)
// ---------------------------------------------------------------------------
module parking_lot_monitor #(
  parameter int N_LANES  = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200,
  parameter int DB_CNT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_lot_monitor_if.slave  bus
);

  localparam int NS   = 2 * N_LANES;
  localparam int DB_W = (DB_CNT < 2) ? 1 : $clog2(DB_CNT);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic signed [CNT_W+1:0] CAP_S = (CNT_W+2)'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_U = CNT_W'(CAPACITY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EN1  = 3'd1;
  localparam logic [2:0] S_EN2  = 3'd2;
  localparam logic [2:0] S_EN3  = 3'd3;
  localparam logic [2:0] S_EX1  = 3'd4;
  localparam logic [2:0] S_EX2  = 3'd5;
  localparam logic [2:0] S_EX3  = 3'd6;

  // -------------------------------------------------------------------------
  // Input path: sensors packed as {b, a}; index s < N_LANES is an outer
  // sensor, s >= N_LANES the inner sensor of lane s - N_LANES.
  // -------------------------------------------------------------------------
  logic [NS-1:0]   raw;
  logic [NS-1:0]   sync1;
  logic [NS-1:0]   sync2;
  logic [NS-1:0]   deb;
  logic [DB_W-1:0] db_cnt [NS];

  assign raw = {bus.b, bus.a};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The counter runs only while the synchronized level disagrees with the
  // debounced one; any agreeing cycle restarts it, so a level must differ
  // for DB_CNT consecutive cycles before it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        db_cnt[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        if (sync2[s] != deb[s]) begin
          if (db_cnt[s] == DB_LAST) begin
            deb[s]    <= sync2[s];
            db_cnt[s] <= '0;
          end else begin
            db_cnt[s] <= db_cnt[s] + DB_W'(1);
          end
        end else begin
          db_cnt[s] <= '0;
        end
      end
    end
  end

  logic [N_LANES-1:0] deb_a;
  logic [N_LANES-1:0] deb_b;

  assign deb_a = deb[N_LANES-1:0];
  assign deb_b = deb[NS-1:N_LANES];

  // -------------------------------------------------------------------------
  // Per-lane direction FSMs
  // -------------------------------------------------------------------------
  logic [2:0]         state    [N_LANES];
  logic [2:0]         state_nx [N_LANES];
  logic [N_LANES-1:0] enter_nx;
  logic [N_LANES-1:0] exit_nx;
  logic [N_LANES-1:0] enter_q;
  logic [N_LANES-1:0] exit_q;

  always_comb begin
    logic [1:0] ab;
    ab       = '0;
    enter_nx = '0;
    exit_nx  = '0;
    for (int unsigned l = 0; l < N_LANES; l++) begin
      state_nx[l] = S_IDLE;
      ab = {deb_a[l], deb_b[l]};
      case (state[l])
        S_IDLE: begin
          // 11 straight from idle has no direction; wait for 00.
          case (ab)
            2'b10:   state_nx[l] = S_EN1;
            2'b01:   state_nx[l] = S_EX1;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        S_EN1: begin
          case (ab)
            2'b11:   state_nx[l] = S_EN2;
            2'b10:   state_nx[l] = S_EN1;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        S_EN2: begin
          case (ab)
            2'b01:   state_nx[l] = S_EN3;
            2'b10:   state_nx[l] = S_EN1;
            2'b11:   state_nx[l] = S_EN2;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        S_EN3: begin
          case (ab)
            2'b00: begin
              state_nx[l] = S_IDLE;
              enter_nx[l] = 1'b1;
            end
            2'b11:   state_nx[l] = S_EN2;
            2'b01:   state_nx[l] = S_EN3;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        S_EX1: begin
          case (ab)
            2'b11:   state_nx[l] = S_EX2;
            2'b01:   state_nx[l] = S_EX1;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        S_EX2: begin
          case (ab)
            2'b10:   state_nx[l] = S_EX3;
            2'b01:   state_nx[l] = S_EX1;
            2'b11:   state_nx[l] = S_EX2;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        S_EX3: begin
          case (ab)
            2'b00: begin
              state_nx[l] = S_IDLE;
              exit_nx[l]  = 1'b1;
            end
            2'b11:   state_nx[l] = S_EX2;
            2'b10:   state_nx[l] = S_EX3;
            default: state_nx[l] = S_IDLE;
          endcase
        end
        default: state_nx[l] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enter_q <= '0;
      exit_q  <= '0;
      for (int unsigned l = 0; l < N_LANES; l++) begin
        state[l] <= S_IDLE;
      end
    end else begin
      enter_q <= enter_nx;
      exit_q  <= exit_nx;
      for (int unsigned l = 0; l < N_LANES; l++) begin
        state[l] <= state_nx[l];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy counter: registered pulses of all lanes net out first, then
  // the sum is clipped to [0, CAPACITY].
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_nx;
  logic [1:0]              err_q;
  logic [1:0]              err_nx;
  logic signed [CNT_W+1:0] n_en;
  logic signed [CNT_W+1:0] n_ex;
  logic signed [CNT_W+1:0] sum;
  logic                    ovf;
  logic                    unf;

  always_comb begin
    n_en = '0;
    n_ex = '0;
    for (int unsigned l = 0; l < N_LANES; l++) begin
      n_en = n_en + (CNT_W+2)'(enter_q[l]);
      n_ex = n_ex + (CNT_W+2)'(exit_q[l]);
    end
    sum      = $signed({2'b00, count_q}) + n_en - n_ex;
    ovf      = 1'b0;
    unf      = 1'b0;
    count_nx = sum[CNT_W-1:0];
    if (sum > CAP_S) begin
      count_nx = CAP_U;
      ovf      = 1'b1;
    end else if (sum < 0) begin
      count_nx = '0;
      unf      = 1'b1;
    end
    // A new error event in the clearing cycle survives the clear.
    err_nx = (bus.clr_err ? 2'b00 : err_q) | {unf, ovf};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= '0;
    end else begin
      count_q <= count_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.enter = enter_q;
  assign bus.exit  = exit_q;
  assign bus.count = count_q;
  assign bus.err   = err_q;
  assign bus.full  = (count_q == CAP_U);
  assign bus.empty = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_monitor.sv
// ---------------------------------------------------------------------------
// tb_parking_lot_monitor
// Directed, table-driven bench for parking_lot_monitor with N_LANES=2,
// CNT_W=4, CAPACITY=3, DB_CNT=4. Each record holds the sensor levels for one
// step, how long they are held, and the occupancy/flag/error state and the
// per-lane pulse counts expected by the end of the step. A hand-written
// sequence checks pulse latency, pulse width and the one-cycle lag of
// count/empty behind the pulse.
// ---------------------------------------------------------------------------
module tb_parking_lot_monitor;

  localparam int N_LANES  = 2;
  localparam int CNT_W    = 4;
  localparam int CAPACITY = 3;
  localparam int DB_CNT   = 4;
  localparam int H        = 20;

  logic clk = 1'b0;
  logic reset;

  parking_lot_monitor_if #(.N_LANES(N_LANES), .CNT_W(CNT_W)) bus ();

  parking_lot_monitor #(
    .N_LANES (N_LANES),
    .CNT_W   (CNT_W),
    .CAPACITY(CAPACITY),
    .DB_CNT  (DB_CNT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       clr;
    logic       rst;
    int         hold;
    int         cnt;
    int         full;
    int         empty;
    int         err;
    int         pulses;   // en0*1000 + en1*100 + ex0*10 + ex1
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Pulse monitor: running totals per lane plus back-to-back pulse detection.
  int         en_tot [2] = '{0, 0};
  int         ex_tot [2] = '{0, 0};
  int         width_bad = 0;
  logic [1:0] en_prev = '0;
  logic [1:0] ex_prev = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus.enter[i]) en_tot[i] <= en_tot[i] + 1;
      if (bus.exit[i])  ex_tot[i] <= ex_tot[i] + 1;
    end
    if (((bus.enter & en_prev) | (bus.exit & ex_prev)) != 2'b00)
      width_bad <= width_bad + 1;
    en_prev <= bus.enter;
    ex_prev <= bus.exit;
  end

  task automatic add(input logic [1:0] a, input logic [1:0] b,
                     input logic clr, input logic rst, input int hold,
                     input int cnt, input int err,
                     input int en0, input int en1, input int ex0, input int ex1);
    vec_t v;
    v.a      = a;
    v.b      = b;
    v.clr    = clr;
    v.rst    = rst;
    v.hold   = hold;
    v.cnt    = cnt;
    v.full   = (cnt == CAPACITY) ? 1 : 0;
    v.empty  = (cnt == 0) ? 1 : 0;
    v.err    = err;
    v.pulses = en0 * 1000 + en1 * 100 + ex0 * 10 + ex1;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   e0, e1, x0, x1, p;
    v = vq[i];
    bus.a       = v.a;
    bus.b       = v.b;
    bus.clr_err = v.clr;
    reset       = v.rst;
    e0 = en_tot[0];
    e1 = en_tot[1];
    x0 = ex_tot[0];
    x1 = ex_tot[1];
    repeat (v.hold) @(negedge clk);
    #1;
    p = (en_tot[0] - e0) * 1000 + (en_tot[1] - e1) * 100
      + (ex_tot[0] - x0) * 10 + (ex_tot[1] - x1);
    check($sformatf("v%0d count", i),  int'(bus.count), v.cnt);
    check($sformatf("v%0d full", i),   int'(bus.full),  v.full);
    check($sformatf("v%0d empty", i),  int'(bus.empty), v.empty);
    check($sformatf("v%0d err", i),    int'(bus.err),   v.err);
    check($sformatf("v%0d pulses", i), p,               v.pulses);
  endtask

  int split;

  initial begin
    int k;
    reset       = 1'b1;
    bus.a       = '0;
    bus.b       = '0;
    bus.clr_err = 1'b0;

    // reset, then first entry on lane 0 up to the last step
    add(2'b00, 2'b00, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    split = vq.size();
    // exit on lane 1; a 2-cycle drop of a while in EX3 must not complete it
    add(2'b00, 2'b10, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b10, 2'b10, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 1);
    // entry with back-up on lane 0: 10 11 10 11 01 00
    add(2'b01, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 1, 0, 1, 0, 0, 0);
    // abort: 10, 00
    add(2'b01, 2'b00, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 1, 0, 0, 0, 0, 0);
    // entries up to capacity, then one refused
    for (int n = 2; n <= 4; n++) begin
      add(2'b01, 2'b00, 0, 0, H, n - 1, 0, 0, 0, 0, 0);
      add(2'b01, 2'b01, 0, 0, H, n - 1, 0, 0, 0, 0, 0);
      add(2'b00, 2'b01, 0, 0, H, n - 1, 0, 0, 0, 0, 0);
      add(2'b00, 2'b00, 0, 0, H, (n > CAPACITY) ? CAPACITY : n,
          (n > CAPACITY) ? 1 : 0, 1, 0, 0, 0);
    end
    add(2'b00, 2'b00, 1, 0, 2, 3, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 5, 3, 0, 0, 0, 0, 0);
    // lane 0 entry and lane 1 exit in lockstep at capacity
    add(2'b01, 2'b10, 0, 0, H, 3, 0, 0, 0, 0, 0);
    add(2'b11, 2'b11, 0, 0, H, 3, 0, 0, 0, 0, 0);
    add(2'b10, 2'b01, 0, 0, H, 3, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 3, 0, 1, 0, 0, 1);
    // underflow from reset
    add(2'b00, 2'b00, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b10, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b10, 2'b10, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 0, 2, 0, 0, 0, 1);
    // reset mid-entry with count 1, sensors still blocked across reset
    add(2'b00, 2'b00, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 1, 0, 1, 0, 0, 0);
    add(2'b01, 2'b00, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 0, H, 1, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    add(2'b01, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b01, 0, 0, H, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, H, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < split; i++) run_vec(i);

    // Last step of the first entry, cycle by cycle: 2 sync + DB_CNT debounce
    // + 1 FSM edge to the pulse, count/empty follow one cycle later.
    bus.a = 2'b00;
    bus.b = 2'b00;
    k = 99;
    for (int j = 1; j <= 30 && k == 99; j++) begin
      @(negedge clk);
      #1;
      if (bus.enter[0]) k = j;
    end
    check("enter_latency", k, 2 + DB_CNT + 1);
    check("count_at_pulse", int'(bus.count), 0);
    check("empty_at_pulse", int'(bus.empty), 1);
    @(negedge clk);
    #1;
    check("enter_width", int'(bus.enter[0]), 0);
    check("count_after_pulse", int'(bus.count), 1);
    check("empty_after_pulse", int'(bus.empty), 0);
    repeat (12) @(negedge clk);
    #1;

    for (int i = split; i < vq.size(); i++) run_vec(i);

    check("pulse_width_violations", width_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
